bmu_result_collector: RTL

- Sits on the output side of the BMU. It tracks the issue strobe (validIn), captures the registered BMU result (resultFf, error) after the BMU's fixed latency, and tags each capture with a sequence number.
- Captured entries are queued in a small FIFO and presented to a downstream consumer over a valid/ready handshake.
- It flags and counts results lost to FIFO overflow.

---
 rtl/bmu_result_collector.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bmu_result_collector.sv
// BMU result collector.
// Follows the BMU issue strobe through a fixed-latency valid pipe and captures
// the BMU's registered result/error when it becomes valid. Each capture is
// tagged with a rolling sequence number and queued in a small FIFO. The FIFO
// head is offered downstream over a valid/ready handshake. Captures that
// arrive while the FIFO is full are dropped, and drops are counted and flagged.
module bmu_result_collector #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 4,
  parameter int SEQ_W   = 8
) (
  input  logic                       clk,
  input  logic                       rstL,
  input  logic                       validIn,
  input  logic [31:0]                resultFf,
  input  logic                       error,
  input  logic                       flush,
  input  logic                       clearSticky,
  output logic                       outValid,
  input  logic                       outReady,
  output logic [31:0]                outResult,
  output logic                       outError,
  output logic [SEQ_W-1:0]           outSeq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflowSticky,
  output logic [SEQ_W-1:0]           dropCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [SEQ_W-1:0] SEQ_ONE  = SEQ_W'(1);

  typedef struct packed {
    logic [31:0]      result;
    logic             err;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  logic [LATENCY-1:0] validPipe;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;
  logic [SEQ_W-1:0]   seq;

  logic               capture;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;
  logic [CNT_W-1:0]   countNext;
  logic [PTR_W-1:0]   rdPtrNext;
  entry_t             newEntry;
  entry_t             headNext;

  // Stage 0 of the valid pipe samples the issue strobe; flush empties it.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL)      validPipe[0] <= 1'b0;
    else if (flush) validPipe[0] <= 1'b0;
    else            validPipe[0] <= validIn;
  end

  // Remaining stages delay the strobe to line up with the BMU's result.
  generate
    for (genvar gi = 1; gi < LATENCY; gi++) begin : gPipe
      always_ff @(posedge clk or negedge rstL) begin
        if (!rstL)      validPipe[gi] <= 1'b0;
        else if (flush) validPipe[gi] <= 1'b0;
        else            validPipe[gi] <= validPipe[gi-1];
      end
    end
  endgenerate

  // Handshake decode, next occupancy and the entry that will be at the head.
  always_comb begin
    capture  = validPipe[LATENCY-1];
    full     = (count == CNT_FULL);
    pop      = outValid && outReady && !flush;
    // A full FIFO still accepts a capture when its head leaves this cycle.
    push     = capture && !flush && (!full || pop);
    drop     = capture && !flush && full && !pop;
    newEntry = '{result: resultFf, err: error, seq: seq};

    countNext = count;
    if (flush)             countNext = '0;
    else if (push && !pop) countNext = count + CNT_ONE;
    else if (pop && !push) countNext = count - CNT_ONE;

    rdPtrNext = pop ? (rdPtr + PTR_ONE) : rdPtr;
    // The only time the new head is the entry being written this cycle is
    // when it lands exactly at the next read slot (empty, or one-left + pop).
    headNext = (push && (rdPtrNext == wrPtr)) ? newEntry : mem[rdPtrNext];
  end

  // FIFO storage; cleared on reset so the head never shows X.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wrPtr] <= newEntry;
    end
  end

  // Pointers and occupancy; flush restarts the FIFO from slot 0.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      rdPtr <= rdPtrNext;
      if (push) wrPtr <= wrPtr + PTR_ONE;
      count <= countNext;
    end
  end

  // Registered head outputs, loaded with the head as it stands after this edge.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      outValid  <= 1'b0;
      outResult <= '0;
      outError  <= 1'b0;
      outSeq    <= '0;
    end else begin
      outValid <= (countNext != '0);
      if (!flush) begin
        outResult <= headNext.result;
        outError  <= headNext.err;
        outSeq    <= headNext.seq;
      end
    end
  end

  // Sequence tag advances on every capture, kept or not, so gaps are visible.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL)        seq <= '0;
    else if (capture) seq <= seq + SEQ_ONE;
  end

  // Overflow tracking: a drop sets the sticky flag ahead of a clear request.
  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      overflowSticky <= 1'b0;
      dropCount      <= '0;
    end else begin
      if (drop)             overflowSticky <= 1'b1;
      else if (clearSticky) overflowSticky <= 1'b0;
      if (drop && (dropCount != '1)) dropCount <= dropCount + SEQ_ONE;
    end
  end

endmodule
